// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage M-extension controller: the instruction decode
// view it receives and its own FSM/funct3 encodings.
package control_itf;

    typedef struct packed {
        logic [6:0] funct7;
        logic [2:0] funct3;
        logic [6:0] opcode;
    } instruction_decode;

    localparam logic [6:0] op_reg = 7'b0110011;
    localparam logic [6:0] op_imm = 7'b0010011;

endpackage

package muldiv_pkg;

    localparam int unsigned CNT_W = 4;
    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } muldiv_state_t;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } muldiv_funct3_t;

endpackage

// File: rtl/muldiv_special_case.sv
// Detects divide/remainder operand pairs whose result is architecturally fixed
// (divide by zero, signed overflow) so the iterative divider can be skipped.
module muldiv_special_case
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [2:0]      funct3_i,
    output logic            bypass_o,
    output logic [XLEN-1:0] bypass_result_o
);

    localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic div_by_zero;
    logic signed_ovf;

    assign div_by_zero = (rs2_i == '0);
    assign signed_ovf  = ~funct3_i[0] && (rs1_i == XLEN_MIN) && (rs2_i == '1);

    // funct3[2] marks div/rem; funct3[1] picks remainder over quotient
    always_comb begin
        bypass_o        = 1'b0;
        bypass_result_o = '0;
        if (funct3_i[2]) begin
            if (div_by_zero) begin
                bypass_o        = 1'b1;
                bypass_result_o = funct3_i[1] ? rs1_i : '1;
            end else if (signed_ovf) begin
                bypass_o        = 1'b1;
                bypass_result_o = funct3_i[1] ? '0 : XLEN_MIN;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_controller.sv
// EX-stage sequencer for M-extension ops: issues to the external multiplier or
// divider, stalls the pipe until the result is captured, and handles flushes.
module ex_muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_i,
    input  control_itf::instruction_decode idecode,
    input  logic                          flush_i,
    input  logic [XLEN-1:0]               rs1_i,
    input  logic [XLEN-1:0]               rs2_i,
    output logic                          mul_start_o,
    output logic [1:0]                    mul_op_o,
    input  logic [XLEN-1:0]               mul_result_i,
    output logic                          div_start_o,
    output logic                          div_signed_o,
    output logic                          div_abort_o,
    input  logic                          div_done_i,
    input  logic [XLEN-1:0]               div_quot_i,
    input  logic [XLEN-1:0]               div_rem_i,
    output logic                          stall_o,
    output logic                          result_valid_o,
    output logic [XLEN-1:0]               result_o,
    output logic                          is_muldiv_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             is_m;
    logic             bypass;
    logic [XLEN-1:0]  bypass_result;

    assign is_m = valid_i
               && (idecode.opcode == control_itf::op_reg)
               && (idecode.funct7 == MULDIV_FUNCT7);

    muldiv_special_case #(
        .XLEN (XLEN)
    ) u_special (
        .rs1_i           (rs1_i),
        .rs2_i           (rs2_i),
        .funct3_i        (idecode.funct3),
        .bypass_o        (bypass),
        .bypass_result_o (bypass_result)
    );

    // Outputs are forced low while rst is asserted, so a synchronous reset is
    // visible on the pins in the same cycle it is applied.
    assign is_muldiv_o = is_m && !rst;
    assign result_o    = rst ? '0 : result_q;

    // Next-state, counter, result capture and handshake outputs
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        mul_start_o    = 1'b0;
        mul_op_o       = 2'b00;
        div_start_o    = 1'b0;
        div_signed_o   = 1'b0;
        div_abort_o    = 1'b0;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;

        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (is_m && !flush_i) begin
                        stall_o = 1'b1;
                        if (!idecode.funct3[2]) begin
                            mul_start_o = 1'b1;
                            mul_op_o    = idecode.funct3[1:0];
                            cnt_d       = CNT_LOAD;
                            state_d     = ST_MUL_WAIT;
                        end else if (bypass) begin
                            result_d = bypass_result;
                            state_d  = ST_DONE;
                        end else begin
                            div_start_o  = 1'b1;
                            div_signed_o = ~idecode.funct3[0];
                            state_d      = ST_DIV_WAIT;
                        end
                    end
                end

                ST_MUL_WAIT: begin
                    if (flush_i) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        stall_o = 1'b1;
                        if (cnt_q == '0) begin
                            result_d = mul_result_i;
                            state_d  = ST_DONE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end

                ST_DIV_WAIT: begin
                    if (flush_i) begin
                        div_abort_o = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        stall_o = 1'b1;
                        if (div_done_i) begin
                            result_d = idecode.funct3[1] ? div_rem_i : div_quot_i;
                            state_d  = ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    result_valid_o = !flush_i;
                    state_d        = ST_IDLE;
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, latency counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_controller.sv
// Directed bench for ex_muldiv_controller: models the external multiplier and
// divider handshakes and checks issue, stall, result and flush/reset behaviour.
module tb_ex_muldiv_controller;
    import muldiv_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MUL_LAT = 3;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           valid_i;
    control_itf::instruction_decode idecode;
    logic                           flush_i;
    logic [XLEN-1:0]                rs1_i, rs2_i;
    logic                           mul_start_o;
    logic [1:0]                     mul_op_o;
    logic [XLEN-1:0]                mul_result_i;
    logic                           div_start_o, div_signed_o, div_abort_o;
    logic                           div_done_i;
    logic [XLEN-1:0]                div_quot_i, div_rem_i;
    logic                           stall_o, result_valid_o, is_muldiv_o;
    logic [XLEN-1:0]                result_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_res;

    ex_muldiv_controller #(
        .XLEN    (XLEN),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .idecode        (idecode),
        .flush_i        (flush_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .mul_start_o    (mul_start_o),
        .mul_op_o       (mul_op_o),
        .mul_result_i   (mul_result_i),
        .div_start_o    (div_start_o),
        .div_signed_o   (div_signed_o),
        .div_abort_o    (div_abort_o),
        .div_done_i     (div_done_i),
        .div_quot_i     (div_quot_i),
        .div_rem_i      (div_rem_i),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .is_muldiv_o    (is_muldiv_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_i        = 1'b0;
        flush_i        = 1'b0;
        idecode.funct7 = 7'd0;
        idecode.funct3 = 3'd0;
        idecode.opcode = 7'd0;
        rs1_i          = '0;
        rs2_i          = '0;
        mul_result_i   = 32'hDEAD_BEEF;
        div_done_i     = 1'b0;
        div_quot_i     = 32'hBAD0_BAD0;
        div_rem_i      = 32'hBAD1_BAD1;
    endtask

    task automatic drive_op(input logic [6:0] f7, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b);
        valid_i        = 1'b1;
        idecode.funct7 = f7;
        idecode.funct3 = f3;
        idecode.opcode = control_itf::op_reg;
        rs1_i          = a;
        rs2_i          = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one M-op and follow it to result_valid_o; cycle 0 is the issue cycle.
    // The multiplier result appears MUL_LAT cycles after issue; the divider
    // reports done at cycle done_at (negative: never).
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int done_at, input logic [31:0] unit_res, input logic [31:0] unit_rem,
                          output int mstarts, output int dstarts, output int stalls, output int vcyc,
                          output logic sgn, output logic [1:0] mop, output logic [31:0] res,
                          output logic stall_v);
        mstarts = 0; dstarts = 0; stalls = 0; vcyc = -1;
        sgn = 1'b0; mop = 2'b00; res = '0; stall_v = 1'b1;
        drive_op(MULDIV_FUNCT7, f3, a, b);
        for (int cyc = 0; cyc < 32; cyc++) begin
            mul_result_i = (cyc == int'(MUL_LAT)) ? unit_res : 32'hDEAD_BEEF;
            div_done_i   = (cyc == done_at);
            div_quot_i   = (cyc == done_at) ? unit_res : 32'hBAD0_BAD0;
            div_rem_i    = (cyc == done_at) ? unit_rem : 32'hBAD1_BAD1;
            #1;
            if (mul_start_o) begin mstarts++; mop = mul_op_o; end
            if (div_start_o) begin dstarts++; sgn = div_signed_o; end
            if (stall_o) stalls++;
            if (result_valid_o) begin
                vcyc    = cyc;
                res     = result_o;
                stall_v = stall_o;
                break;
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input int done_at, input logic [31:0] unit_res,
                           input logic [31:0] unit_rem, input logic [31:0] exp_res,
                           input int exp_mstart, input int exp_dstart, input int exp_stalls,
                           input logic exp_sgn, input logic [1:0] exp_mop);
        int ms, ds, st, vc;
        logic sg, sv;
        logic [1:0] mo;
        logic [31:0] rs;
        run_op(f3, a, b, done_at, unit_res, unit_rem, ms, ds, st, vc, sg, mo, rs, sv);
        check({tag, "/result"},      64'(rs),  64'(exp_res));
        check({tag, "/mul_starts"},  64'(ms),  64'(exp_mstart));
        check({tag, "/div_starts"},  64'(ds),  64'(exp_dstart));
        check({tag, "/stall_cycles"}, 64'(st), 64'(exp_stalls));
        check({tag, "/valid_cycle"}, 64'(vc),  64'(exp_stalls));
        check({tag, "/stall_in_done"}, 64'(sv), 64'd0);
        if (exp_dstart != 0) check({tag, "/div_signed"}, 64'(sg), 64'(exp_sgn));
        if (exp_mstart != 0) check({tag, "/mul_op"},     64'(mo), 64'(exp_mop));
        #1;
        check({tag, "/valid_after"}, 64'(result_valid_o), 64'd0);
        check({tag, "/result_hold"}, 64'(result_o),       64'(exp_res));
        check({tag, "/stall_after"}, 64'(stall_o),        64'd0);
        last_res = exp_res;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_seen;
        idle_inputs();
        rst = 1'b1;
        drive_op(MULDIV_FUNCT7, F3_MUL, 32'd3, 32'd4);
        next_cycle();
        #1;
        check("rst/mul_start",    64'(mul_start_o),    64'd0);
        check("rst/stall",        64'(stall_o),        64'd0);
        check("rst/is_muldiv",    64'(is_muldiv_o),    64'd0);
        check("rst/result",       64'(result_o),       64'd0);
        check("rst/result_valid", 64'(result_valid_o), 64'd0);
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        #1;
        check("post_rst/result", 64'(result_o), 64'd0);
        check("post_rst/outs",   64'({mul_start_o, mul_op_o, div_start_o, div_signed_o, div_abort_o,
                                      stall_o, result_valid_o, is_muldiv_o}), 64'd0);
        last_res = 32'd0;

        // Non-M instructions pass straight through
        next_cycle();
        drive_op(7'b0000000, 3'b000, 32'd1, 32'd2);
        #1;
        check("add/is_muldiv", 64'(is_muldiv_o), 64'd0);
        check("add/stall",     64'(stall_o),     64'd0);
        check("add/starts",    64'({mul_start_o, div_start_o}), 64'd0);
        next_cycle();
        idecode.opcode = control_itf::op_imm;
        idecode.funct7 = MULDIV_FUNCT7;
        #1;
        check("opimm/is_muldiv", 64'(is_muldiv_o), 64'd0);
        check("opimm/stall",     64'(stall_o),     64'd0);
        next_cycle();
        idle_inputs();
        #1;
        check("add_after/result_valid", 64'(result_valid_o), 64'd0);
        next_cycle();

        //        tag        f3         rs1           rs2           done  unit_res      unit_rem      expected      ms ds st sg  mop
        test_op("mul",     F3_MUL,   32'd7,        32'd6,        -1, 32'd42,       32'd0,        32'd42,       1, 0, 4, 0, 2'd0);
        test_op("mulhu",   F3_MULHU, 32'hFFFF_FFFF, 32'd2,       -1, 32'h55,       32'd0,        32'h55,       1, 0, 4, 0, 2'd3);
        test_op("divu",    F3_DIVU,  32'd100,      32'd7,         5, 32'd14,       32'd2,        32'd14,       0, 1, 6, 0, 2'd0);
        test_op("rem",     F3_REM,   32'd100,      32'd7,         3, 32'd14,       32'd2,        32'd2,        0, 1, 4, 1, 2'd0);
        test_op("div_z",   F3_DIV,   32'd5,        32'd0,        -1, 32'd0,        32'd0,        32'hFFFF_FFFF, 0, 0, 1, 0, 2'd0);
        test_op("rem_z",   F3_REM,   32'd5,        32'd0,        -1, 32'd0,        32'd0,        32'd5,        0, 0, 1, 0, 2'd0);
        test_op("div_ovf", F3_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 32'd0,      32'd0,        32'h8000_0000, 0, 0, 1, 0, 2'd0);
        test_op("rem_ovf", F3_REM,   32'h8000_0000, 32'hFFFF_FFFF, -1, 32'd0,      32'd0,        32'd0,        0, 0, 1, 0, 2'd0);
        test_op("divu_big", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'd0,       32'h8000_0000, 32'd0,       0, 1, 3, 0, 2'd0);
        test_op("rem_last", F3_REM,  32'd23,       32'd5,         1, 32'd4,        32'd3,        32'd3,        0, 1, 2, 1, 2'd0);

        // Flush two cycles into a divide; a late done must be ignored
        drive_op(MULDIV_FUNCT7, F3_DIV, 32'd100, 32'd7);
        #1;
        check("fl_div/start", 64'(div_start_o), 64'd1);
        next_cycle();
        next_cycle();
        flush_i = 1'b1;
        #1;
        check("fl_div/abort",        64'(div_abort_o),    64'd1);
        check("fl_div/stall",        64'(stall_o),        64'd0);
        check("fl_div/result_valid", 64'(result_valid_o), 64'd0);
        next_cycle();
        idle_inputs();
        #1;
        check("fl_div/abort_once", 64'(div_abort_o), 64'd0);
        check("fl_div/stall_idle", 64'(stall_o),     64'd0);
        rv_seen = 0;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            div_done_i = (k == 1);
            div_quot_i = 32'd14;
            div_rem_i  = 32'd2;
            #1;
            if (result_valid_o || stall_o || div_abort_o) rv_seen++;
        end
        idle_inputs();
        check("fl_div/late_done_ignored", 64'(rv_seen),  64'd0);
        check("fl_div/result_hold",       64'(result_o), 64'(last_res));

        // Flush in the same cycle the multiplier counter expires
        next_cycle();
        drive_op(MULDIV_FUNCT7, F3_MUL, 32'd9, 32'd9);
        #1;
        check("fl_mul/start", 64'(mul_start_o), 64'd1);
        next_cycle();
        next_cycle();
        next_cycle();
        flush_i      = 1'b1;
        mul_result_i = 32'h0000_1234;
        #1;
        check("fl_mul/stall",        64'(stall_o),        64'd0);
        check("fl_mul/result_valid", 64'(result_valid_o), 64'd0);
        next_cycle();
        idle_inputs();
        #1;
        check("fl_mul/no_valid",    64'(result_valid_o), 64'd0);
        check("fl_mul/result_hold", 64'(result_o),       64'(last_res));
        check("fl_mul/stall_idle",  64'(stall_o),        64'd0);

        // Flush together with a new M-op in IDLE: nothing is issued
        next_cycle();
        drive_op(MULDIV_FUNCT7, F3_DIVU, 32'd50, 32'd5);
        flush_i = 1'b1;
        #1;
        check("fl_idle/starts", 64'({mul_start_o, div_start_o}), 64'd0);
        check("fl_idle/stall",  64'(stall_o), 64'd0);
        next_cycle();
        idle_inputs();
        #1;
        check("fl_idle/stall_next", 64'(stall_o),        64'd0);
        check("fl_idle/no_valid",   64'(result_valid_o), 64'd0);

        // Reset while waiting on the multiplier
        next_cycle();
        drive_op(MULDIV_FUNCT7, F3_MUL, 32'd7, 32'd6);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        check("rst_mul/stall",     64'(stall_o),     64'd0);
        check("rst_mul/result",    64'(result_o),    64'd0);
        check("rst_mul/is_muldiv", 64'(is_muldiv_o), 64'd0);
        check("rst_mul/abort",     64'(div_abort_o), 64'd0);
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        mul_result_i = 32'd42;
        #1;
        check("rst_mul_after/outs", 64'({mul_start_o, mul_op_o, div_start_o, div_signed_o, div_abort_o,
                                         stall_o, result_valid_o, is_muldiv_o}), 64'd0);
        check("rst_mul_after/result", 64'(result_o), 64'd0);
        rv_seen = 0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            #1;
            if (result_valid_o || stall_o) rv_seen++;
        end
        check("rst_mul/stays_idle", 64'(rv_seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_controller.md
EX_MULDIV_CONTROLLER -- requirements
Module: ex_muldiv_controller

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter MUL_LAT, default 3, fixed multiplier pipeline latency in cycles (legal 1..15).
REQ-003 clk  in  1  sole clock; rst  in  1  synchronous, active-high reset.
REQ-004 valid_i  in  1  EX stage holds a valid instruction; idecode  in  control_itf::instruction_decode  opcode/funct3/funct7 of that instruction.
REQ-005 flush_i  in  1  abort current instruction; rs1_i, rs2_i  in  XLEN  operands.
REQ-006 mul_start_o  out  1  one-cycle issue pulse; mul_op_o  out  2  funct3[1:0]; mul_result_i  in  XLEN.
REQ-007 div_start_o  out  1  issue pulse; div_signed_o  out  1; div_abort_o  out  1; div_done_i  in  1; div_quot_i, div_rem_i  in  XLEN.
REQ-008 stall_o  out  1  hold upstream stages; result_valid_o  out  1; result_o  out  XLEN; is_muldiv_o  out  1  decode flag.

Function
REQ-009 is_muldiv_o SHALL be 1 iff valid_i, opcode==op_reg and funct7==7'b0000001; funct3 selects mul/mulh/mulhsu/mulhu/div/divu/rem/remu (000..111).
REQ-010 FSM states IDLE, MUL_WAIT, DIV_WAIT, DONE; only IDLE accepts a new instruction.
REQ-011 Non-M instruction in IDLE: stall_o=0, no start pulse, state unchanged.
REQ-012 IDLE with mul op: mul_start_o=1 same cycle, counter loaded MUL_LAT-1, -> MUL_WAIT; stall_o=1.
REQ-013 MUL_WAIT: counter decrements per cycle; at counter==0 capture mul_result_i into result register, -> DONE; total stall = MUL_LAT+1 cycles from issue.
REQ-014 IDLE with div/rem op, non-special: div_start_o=1, div_signed_o = ~funct3[0], -> DIV_WAIT; stall_o=1.
REQ-015 DIV_WAIT: stall_o=1 until div_done_i; on done capture div_quot_i (funct3[1]==0) or div_rem_i (funct3[1]==1), -> DONE.
REQ-016 Special cases bypass the divider (no div_start_o), -> DONE next cycle: divisor 0 -> quotient all-ones, remainder rs1_i; signed rs1_i==MIN and rs2_i==all-ones -> quotient MIN, remainder 0.
REQ-017 DONE: result_valid_o=1, stall_o=0, result_o=result register, -> IDLE; result_o holds last value otherwise.
REQ-018 flush_i in any state: -> IDLE next cycle, no result_valid_o; stall_o=0 in the flush cycle; div_abort_o=1 for one cycle if flushed in DIV_WAIT.
REQ-019 flush_i with div_done_i or counter expiry same cycle: flush wins, result discarded.
REQ-020 flush_i with new M-op in IDLE: no start pulse issued.
REQ-021 div_done_i outside DIV_WAIT SHALL be ignored.
REQ-022 All arithmetic compares at XLEN width; MIN = 1 followed by XLEN-1 zeros.

Reset
REQ-023 rst: state IDLE, counter 0, result register 0; all outputs 0 in the reset cycle and the cycle after.
REQ-024 rst mid-operation: identical to REQ-023; no div_abort_o pulse.

Structure
REQ-025 Package muldiv_pkg: muldiv_state_t enum, muldiv_funct3_t enum, constant MULDIV_FUNCT7.
REQ-026 One combinational sub-module muldiv_special_case: computes bypass flag and bypass result from rs1_i, rs2_i, funct3.
REQ-027 Only the FSM, counter and result register are sequential.

Verification
REQ-028 mul, rs1=7, rs2=6, MUL_LAT=3, mul_result_i=42 at expiry -> one start pulse, stall 4 cycles, result_valid_o with 42.
REQ-029 divu 100/7, div_done_i 5 cycles after start with quot 14 -> result 14, stall released exactly in DONE cycle.
REQ-030 div 5/0 -> no div_start_o, result 0xFFFFFFFF; rem 5/0 -> result 5; each one stall cycle.
REQ-031 div 0x80000000/0xFFFFFFFF -> result 0x80000000; rem same operands -> 0.
REQ-032 div issued, flush_i 2 cycles later -> div_abort_o one pulse, no result_valid_o; later div_done_i ignored.
REQ-033 add (funct7=0) with valid_i -> stall_o=0, is_muldiv_o=0, no start pulses; rst during MUL_WAIT -> IDLE, outputs 0.
